// File: rtl/fft_frame_seq_pkg.sv
// fft_frame_seq_pkg: shared definitions for the FFT frame sequencer.
//   fft_seq_state_t : sequencer phases (LOAD, FLUSH, COMPUTE, UNLOAD)
//   FFT_MEM_SIZE    : default frame length / working memory depth
//   FFT_VLW_WDT     : default sample width (packed re/im)
//   bitrev()        : reverses the low addr_wdt bits of an index
package fft_frame_seq_pkg;

   localparam int FFT_MEM_SIZE = 1024;
   localparam int FFT_VLW_WDT  = 32;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      FLUSH   = 2'd1,
      COMPUTE = 2'd2,
      UNLOAD  = 2'd3
   } fft_seq_state_t;

   // Bits at and above addr_wdt come back as zero; callers truncate.
   function automatic logic [15:0] bitrev(input logic [15:0] idx, input int addr_wdt);
      logic [15:0] r;
      r = '0;
      for (int b = 0; b < 16; b++)
         if (b < addr_wdt) r[b] = idx[addr_wdt-1-b];
      return r;
   endfunction

endpackage

// File: rtl/fft_seq_out_fifo.sv
// fft_seq_out_fifo: 3-entry output FIFO for the unload path.
//   clk, rst_n : clock, async active-low reset
//   flush      : sync empty (drops all entries)
//   push, din  : write side; caller guarantees no push when full
//   pop        : read side; caller guarantees no pop when empty
//   dout       : head entry, stable until popped
//   empty, occ : status; occ feeds the read-credit logic
module fft_seq_out_fifo #(
   parameter int WDT = 33
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           push,
   input  logic [WDT-1:0] din,
   input  logic           pop,
   output logic [WDT-1:0] dout,
   output logic           empty,
   output logic [1:0]     occ
);

   logic [2:0][WDT-1:0] mem;
   logic [1:0]          rd_ptr, wr_ptr, cnt;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         cnt <= cnt + 2'(push) - 2'(pop);
      end
   end

   assign dout  = mem[rd_ptr];
   assign empty = (cnt == 2'd0);
   assign occ   = cnt;

endmodule

// File: rtl/fft_frame_seq.sv
// fft_frame_seq: single-buffer frame sequencer around the FFT core.
// Loads one frame from s_axis into working memory, pulses fft_start,
// waits for fft_done, then streams the result memory out on m_axis.
//   clk, rst_n          : clock, async active-low reset
//   abort               : sync flush back to LOAD
//   s_axis_*            : input stream (tready high only in LOAD)
//   mem_wr_*            : registered memory write port
//   fft_start/fft_done  : core handshake (one-cycle pulses)
//   mem_rd_en/addr/data : read port, data one cycle after request
//   m_axis_*            : output stream, tlast on beat FFT_SIZE-1
//   frame_cnt           : completed frames (wraps)
//   err_tlast_early/late, err_clr : sticky TLAST mismatch flags
module fft_frame_seq
   import fft_frame_seq_pkg::*;
#(
   parameter int  FFT_SIZE    = FFT_MEM_SIZE,
   parameter int  VLW_WDT     = FFT_VLW_WDT,
   parameter bit  BITREV_LOAD = 1'b0,
   localparam int ADDR_WDT    = $clog2(FFT_SIZE)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                abort,
   input  logic [VLW_WDT-1:0]  s_axis_tdata,
   input  logic                s_axis_tvalid,
   input  logic                s_axis_tlast,
   output logic                s_axis_tready,
   output logic                mem_wr_en,
   output logic [ADDR_WDT-1:0] mem_wr_addr,
   output logic [VLW_WDT-1:0]  mem_wr_data,
   output logic                fft_start,
   input  logic                fft_done,
   output logic                mem_rd_en,
   output logic [ADDR_WDT-1:0] mem_rd_addr,
   input  logic [VLW_WDT-1:0]  mem_rd_data,
   output logic [VLW_WDT-1:0]  m_axis_tdata,
   output logic                m_axis_tvalid,
   output logic                m_axis_tlast,
   input  logic                m_axis_tready,
   output logic [15:0]         frame_cnt,
   output logic                err_tlast_early,
   output logic                err_tlast_late,
   input  logic                err_clr
);

   localparam logic [ADDR_WDT-1:0] LAST_IDX = ADDR_WDT'(FFT_SIZE - 1);

   fft_seq_state_t      state, state_nxt;
   logic [ADDR_WDT-1:0] wr_cnt, ld_addr;
   logic [ADDR_WDT:0]   rd_cnt;       // MSB set once all reads are issued
   logic                rd_pend, rd_pend_last;
   logic                hs_in, hs_out, in_last, out_last_hs;
   logic [1:0]          fifo_occ;
   logic                fifo_empty;
   logic                set_early, set_late;

   assign s_axis_tready = (state == LOAD);
   assign hs_in         = s_axis_tvalid & s_axis_tready;
   assign in_last       = (wr_cnt == LAST_IDX);
   assign hs_out        = m_axis_tvalid & m_axis_tready;
   assign out_last_hs   = hs_out & m_axis_tlast;
   assign ld_addr       = BITREV_LOAD ? ADDR_WDT'(bitrev(16'(wr_cnt), ADDR_WDT)) : wr_cnt;

   // Read credit: FIFO entries plus the one possible in-flight read must
   // stay below FIFO depth so returning data always has a slot.
   assign mem_rd_en   = (state == UNLOAD) && !rd_cnt[ADDR_WDT] &&
                        (({1'b0, fifo_occ} + {2'b00, rd_pend}) < 3'd3);
   assign mem_rd_addr = rd_cnt[ADDR_WDT-1:0];

   // A beat accepted in the abort cycle is flushed, so it neither writes
   // nor raises a TLAST error.
   assign set_early = hs_in & ~abort & s_axis_tlast & ~in_last;
   assign set_late  = hs_in & ~abort & ~s_axis_tlast & in_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         LOAD:    if (hs_in && in_last) state_nxt = FLUSH;
         FLUSH:   state_nxt = COMPUTE;
         COMPUTE: if (fft_done) state_nxt = UNLOAD;
         UNLOAD:  if (out_last_hs) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
      if (abort) state_nxt = LOAD;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_wr_en       <= 1'b0;
         mem_wr_addr     <= '0;
         mem_wr_data     <= '0;
         fft_start       <= 1'b0;
         wr_cnt          <= '0;
         rd_cnt          <= '0;
         rd_pend         <= 1'b0;
         rd_pend_last    <= 1'b0;
         frame_cnt       <= '0;
         err_tlast_early <= 1'b0;
         err_tlast_late  <= 1'b0;
      end else begin
         mem_wr_en <= hs_in & ~abort;
         if (hs_in) begin
            mem_wr_addr <= ld_addr;
            mem_wr_data <= s_axis_tdata;
         end
         fft_start    <= (state == FLUSH) & ~abort;
         rd_pend      <= mem_rd_en & ~abort;
         rd_pend_last <= mem_rd_en & (rd_cnt[ADDR_WDT-1:0] == LAST_IDX);
         if (abort) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
         end else begin
            // wr_cnt wraps to 0 on the last beat since FFT_SIZE is 2^n
            if (hs_in)     wr_cnt <= wr_cnt + ADDR_WDT'(1);
            if (mem_rd_en) rd_cnt <= rd_cnt + (ADDR_WDT+1)'(1);
            if (out_last_hs) begin
               rd_cnt    <= '0;
               frame_cnt <= frame_cnt + 16'd1;
            end
         end
         // set beats clear
         err_tlast_early <= set_early | (err_tlast_early & ~err_clr);
         err_tlast_late  <= set_late  | (err_tlast_late  & ~err_clr);
      end
   end

   fft_seq_out_fifo #(
      .WDT (VLW_WDT + 1)
   ) u_out_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (abort),
      .push  (rd_pend),
      .din   ({rd_pend_last, mem_rd_data}),
      .pop   (hs_out),
      .dout  ({m_axis_tlast, m_axis_tdata}),
      .empty (fifo_empty),
      .occ   (fifo_occ)
   );

   assign m_axis_tvalid = ~fifo_empty;

endmodule

// File: tb/tb_fft_frame_seq.sv
// Scoreboard bench for fft_frame_seq at FFT_SIZE=8. A linear-load instance
// drives the memory model and output checks; a bit-reversed instance sees
// the same stimulus and only its write addresses are checked.
`timescale 1ns/1ps
module tb_fft_frame_seq;

   localparam int N  = 8;
   localparam int W  = 32;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          abort = 1'b0;
   logic          err_clr = 1'b0;
   logic [W-1:0]  s_tdata = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          fft_done;
   logic          m_tready;
   logic [W-1:0]  rd_data = '0;

   logic          s_tready, wr_en, fft_start, rd_en, m_tvalid, m_tlast;
   logic [AW-1:0] wr_addr, rd_addr;
   logic [W-1:0]  wr_data, m_tdata;
   logic [15:0]   frame_cnt;
   logic          err_early, err_late;

   logic          b_s_tready, b_wr_en, b_fft_start, b_rd_en, b_m_tvalid, b_m_tlast;
   logic [AW-1:0] b_wr_addr, b_rd_addr;
   logic [W-1:0]  b_wr_data, b_m_tdata;
   logic [15:0]   b_frame_cnt;
   logic          b_err_early, b_err_late;

   fft_frame_seq #(.FFT_SIZE(N), .VLW_WDT(W), .BITREV_LOAD(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tready(s_tready),
      .mem_wr_en(wr_en), .mem_wr_addr(wr_addr), .mem_wr_data(wr_data),
      .fft_start(fft_start), .fft_done(fft_done),
      .mem_rd_en(rd_en), .mem_rd_addr(rd_addr), .mem_rd_data(rd_data),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
      .m_axis_tready(m_tready),
      .frame_cnt(frame_cnt), .err_tlast_early(err_early), .err_tlast_late(err_late),
      .err_clr(err_clr)
   );

   fft_frame_seq #(.FFT_SIZE(N), .VLW_WDT(W), .BITREV_LOAD(1'b1)) dut_br (
      .clk(clk), .rst_n(rst_n), .abort(abort),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
      .s_axis_tready(b_s_tready),
      .mem_wr_en(b_wr_en), .mem_wr_addr(b_wr_addr), .mem_wr_data(b_wr_data),
      .fft_start(b_fft_start), .fft_done(fft_done),
      .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_rd_data(rd_data),
      .m_axis_tdata(b_m_tdata), .m_axis_tvalid(b_m_tvalid), .m_axis_tlast(b_m_tlast),
      .m_axis_tready(m_tready),
      .frame_cnt(b_frame_cnt), .err_tlast_early(b_err_early), .err_tlast_late(b_err_late),
      .err_clr(err_clr)
   );

   always #5 clk = ~clk;

   int errs = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Working memory model: 1-cycle read latency.
   logic [W-1:0] mem [N];
   always @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

   // Core stub: done 20 cycles after start, or a lone pulse on request.
   logic stub_en = 1'b1;
   logic spurious = 1'b0;
   initial begin
      fft_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_n && fft_start && stub_en) begin
            repeat (20) @(posedge clk);
            #1 fft_done = 1'b1;
            @(posedge clk);
            #1 fft_done = 1'b0;
         end else if (spurious) begin
            @(posedge clk);
            #1 fft_done = 1'b1;
            @(posedge clk);
            #1 fft_done = 1'b0;
         end
      end
   end

   logic rnd_mode = 1'b0;
   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1 m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Scoreboard queues and monitor.
   logic [W:0]      oq  [$];
   logic [AW+W-1:0] wq1 [$];
   logic [AW-1:0]   wq2 [$];
   int              out_hs = 0;
   logic            stall_prev = 1'b0;
   logic [W+1:0]    stall_val = '0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_en) begin
            chk("write expected", wq1.size() > 0, 1);
            if (wq1.size() > 0) chk("write addr/data", {wr_addr, wr_data}, wq1.pop_front());
         end
         if (b_wr_en) begin
            chk("bitrev write expected", wq2.size() > 0, 1);
            if (wq2.size() > 0) chk("bitrev addr", b_wr_addr, wq2.pop_front());
         end
         if (stall_prev) chk("stall hold", {m_tvalid, m_tlast, m_tdata}, stall_val);
         if (m_tvalid && m_tready) begin
            out_hs++;
            chk("output expected", oq.size() > 0, 1);
            if (oq.size() > 0) chk("output beat", {m_tlast, m_tdata}, oq.pop_front());
         end
         stall_prev = m_tvalid && !m_tready && !abort;
         stall_val  = {m_tvalid, m_tlast, m_tdata};
      end else begin
         stall_prev = 1'b0;
      end
   end

   // Beat i of frame f carries f*256+i; the core stub leaves memory as-is,
   // so output beat k equals the beat loaded at linear address k.
   task automatic send_frame(input int f, input bit bad_last);
      logic [AW-1:0] brev [N];
      brev = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
      for (int i = 0; i < N; i++) begin
         logic [W-1:0] d;
         d = W'(f * 256 + i);
         @(posedge clk);
         #1;
         s_tvalid = 1'b1;
         s_tdata  = d;
         s_tlast  = bad_last ? (i == 3) : (i == N - 1);
         wq1.push_back({AW'(i), d});
         wq2.push_back(brev[i]);
         oq.push_back({(i == N - 1), d});
         @(negedge clk);
         chk("s_tready in LOAD", s_tready, 1);
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_frame(input int exp);
      int k;
      k = 0;
      while (frame_cnt != 16'(exp) && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("frame complete", frame_cnt, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int base;
      // reset values
      #2;
      chk("reset s_tready", s_tready, 1);
      chk("reset outputs", {wr_en, fft_start, rd_en, m_tvalid, m_tlast, err_early, err_late}, 0);
      chk("reset frame_cnt", frame_cnt, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // frame 1: ramp, latency and throughput
      send_frame(0, 1'b0);
      @(negedge clk); chk("fft_start t+1", fft_start, 0);
      @(negedge clk); chk("fft_start t+2", fft_start, 1);
      @(negedge clk); chk("fft_start t+3", fft_start, 0);
      k = 0;
      while (!fft_done && k < 200) begin @(negedge clk); k++; end
      chk("fft_done seen", fft_done, 1);
      @(negedge clk);
      chk("first read d+1", rd_en, 1);
      chk("tvalid d+1", m_tvalid, 0);
      @(negedge clk); chk("tvalid d+2", m_tvalid, 0);
      for (int b = 0; b < N; b++) begin
         @(negedge clk);
         chk("no bubble", m_tvalid, 1);
         chk("tlast position", m_tlast, (b == N - 1));
      end
      @(negedge clk);
      chk("LOAD after unload", s_tready, 1);
      chk("frame_cnt after frame 1", frame_cnt, 1);
      chk("flags clean", {err_early, err_late}, 0);

      // TLAST early on beat 3, missing on beat 7
      send_frame(1, 1'b1);
      @(negedge clk);
      chk("err flags set", {err_early, err_late}, 2'b11);
      wait_frame(2);
      chk("flags sticky", {err_early, err_late}, 2'b11);
      @(posedge clk); #1 err_clr = 1'b1;
      @(posedge clk); #1 err_clr = 1'b0;
      @(negedge clk);
      chk("err_clr", {err_early, err_late}, 2'b00);

      // random backpressure over 4 frames
      rnd_mode = 1'b1;
      for (int f = 2; f < 6; f++) begin
         send_frame(f, 1'b0);
         wait_frame(f + 1);
      end
      rnd_mode = 1'b0;
      repeat (2) @(posedge clk);

      // abort after 3 output beats
      base = out_hs;
      send_frame(6, 1'b0);
      k = 0;
      while (out_hs < base + 3 && k < 500) begin @(negedge clk); k++; end
      chk("abort point reached", out_hs, base + 3);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      oq.delete();
      @(negedge clk);
      chk("abort tvalid", m_tvalid, 0);
      chk("abort s_tready", s_tready, 1);
      chk("abort frame_cnt", frame_cnt, 6);
      repeat (4) begin
         @(negedge clk);
         chk("abort stays idle", {m_tvalid, rd_en, fft_start}, 0);
      end
      send_frame(7, 1'b0);
      wait_frame(7);

      // async reset while in COMPUTE
      stub_en = 1'b0;
      send_frame(8, 1'b0);
      k = 0;
      while (!fft_start && k < 50) begin @(negedge clk); k++; end
      chk("start before reset", fft_start, 1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset s_tready", s_tready, 1);
      chk("async reset outputs", {wr_en, fft_start, rd_en, m_tvalid, m_tlast, err_early, err_late}, 0);
      chk("async reset frame_cnt", frame_cnt, 0);
      oq.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      spurious = 1'b1;
      @(posedge clk); #1 spurious = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("spurious done ignored", {s_tready, rd_en, m_tvalid, fft_start}, 4'b1000);
      end

      chk("scoreboard drained", oq.size() + wq1.size() + wq2.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
